// File: rtl/div_iter_restoring.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_restoring
// Description : Multi-cycle signed integer divider, radix-2 restoring
//               shift-subtract, one quotient bit per clock. Quotient is
//               truncated toward zero; divide-by-zero raises data_exception.
//               Optional remainder output enabled by defining DIV_REMAINDER_EN.
// Revision    : 1.0  initial release
// ============================================================================
module div_iter_restoring #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
`ifdef DIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  localparam int                c_CNT_W    = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]   r_q;        // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0]   r_rem;      // partial remainder, always < |divisor|
  logic [WIDTH-1:0]   r_mb;       // divisor magnitude (2^(WIDTH-1) representable unsigned)
  logic               r_sign_q;
  logic               r_dz;
  logic [c_CNT_W-1:0] r_cnt;
`ifdef DIV_REMAINDER_EN
  logic               r_sign_r;
`endif

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_rsh;
  logic [WIDTH-1:0]   w_nmb;
  logic [WIDTH-1:0]   w_diff;
  logic               w_ge;

  // Operand magnitudes; negating INT_MIN gives 2^(WIDTH-1) read as unsigned.
  assign w_abs_a = operandA[WIDTH-1] ? (~operandA + WIDTH'(1)) : operandA;
  assign w_abs_b = operandB[WIDTH-1] ? (~operandB + WIDTH'(1)) : operandB;

  // Partial remainder after the left shift, one bit wider than a word.
  assign w_rsh = {r_rem, r_q[WIDTH-1]};
  assign w_nmb = ~r_mb;

  // Subtract w_rsh - {0,|B|} as add with inverted divisor and carry-in 1;
  // carry out of the (WIDTH+1)-bit sum means the difference is non-negative.
  always_comb begin : cla_sub
    logic w_carry;
    w_carry = 1'b1;
    w_diff  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_diff[i] = w_rsh[i] ^ w_nmb[i] ^ w_carry;
      w_carry   = (w_rsh[i] & w_nmb[i]) | ((w_rsh[i] ^ w_nmb[i]) & w_carry);
    end
    // Top bit: divisor extension bit is 0, inverted to 1.
    w_ge = w_rsh[WIDTH] | w_carry;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode and ready strobe; a start request overrides any state.
  always_comb begin
    w_state_nxt    = r_state;
    data_resultRDY = (r_state == S_DONE);
    if (ctrl_div) begin
      w_state_nxt = (operandB == '0) ? S_FIX : S_RUN;
    end else begin
      unique case (r_state)
        S_IDLE: w_state_nxt = S_IDLE;
        S_RUN:  w_state_nxt = (r_cnt == c_CNT_LAST) ? S_FIX : S_RUN;
        S_FIX:  w_state_nxt = S_DONE;
        S_DONE: w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: latch operands on start, iterate in RUN, sign-correct in FIX.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q            <= '0;
      r_rem          <= '0;
      r_mb           <= '0;
      r_sign_q       <= 1'b0;
      r_dz           <= 1'b0;
      r_cnt          <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
`ifdef DIV_REMAINDER_EN
      r_sign_r       <= 1'b0;
      data_remainder <= '0;
`endif
    end else if (ctrl_div) begin
      r_q            <= w_abs_a;
      r_rem          <= '0;
      r_mb           <= w_abs_b;
      r_sign_q       <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
      r_dz           <= (operandB == '0);
      r_cnt          <= '0;
      data_exception <= (operandB == '0);
`ifdef DIV_REMAINDER_EN
      r_sign_r       <= operandA[WIDTH-1];
`endif
    end else begin
      unique case (r_state)
        S_RUN: begin
          r_rem <= w_ge ? w_diff : w_rsh[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + c_CNT_W'(1);
        end
        S_FIX: begin
          if (r_dz)          data_result <= '0;
          else if (r_sign_q) data_result <= ~r_q + WIDTH'(1);
          else               data_result <= r_q;
`ifdef DIV_REMAINDER_EN
          if (r_dz)          data_remainder <= '0;
          else if (r_sign_r) data_remainder <= ~r_rem + WIDTH'(1);
          else               data_remainder <= r_rem;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_iter_restoring.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_iter_restoring
// Description : Self-checking bench for div_iter_restoring: latency, signed
//               quotient/remainder, divide-by-zero, abort/restart, reset.
// Revision    : 1.0  initial release
// ============================================================================
module tb_div_iter_restoring;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         ctrl_div = 1'b0;
  logic [W-1:0] operandA = '0;
  logic [W-1:0] operandB = '0;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
`ifdef DIV_REMAINDER_EN
  logic [W-1:0] data_remainder;
`endif

  int n_vec = 0;
  int n_err = 0;

  div_iter_restoring #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_div       (ctrl_div),
    .operandA       (operandA),
    .operandB       (operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
`ifdef DIV_REMAINDER_EN
    ,
    .data_remainder (data_remainder)
`endif
  );

  always #5 clock = ~clock;

  // Reference: plain signed arithmetic at 64 bits, truncated back to W bits.
  function automatic logic [W-1:0] ref_quot(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    if (b == '0) return '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return W'(sa / sb);
  endfunction

  function automatic logic [W-1:0] ref_rem(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    if (b == '0) return '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return W'(sa % sb);
  endfunction

  // Issue a single-cycle start; returns just after the start edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    operandA = a;
    operandB = b;
    ctrl_div = 1'b1;
    @(posedge clock);
    #1;
    ctrl_div = 1'b0;
    operandA = $urandom;
    operandB = $urandom;
  endtask

  // Count edges until ready is seen (bounded).
  task automatic wait_rdy(input int max, output int lat);
    lat = 0;
    while (data_resultRDY !== 1'b1 && lat < max) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clock);
    #1;
    n_vec++; if (data_resultRDY !== 1'b0) begin n_err++; $display("FAIL reset_rdy got %b want 0", data_resultRDY); end
    n_vec++; if (data_result !== '0) begin n_err++; $display("FAIL reset_result got %h want 0", data_result); end
    n_vec++; if (data_exception !== 1'b0) begin n_err++; $display("FAIL reset_exc got %b want 0", data_exception); end
`ifdef DIV_REMAINDER_EN
    n_vec++; if (data_remainder !== '0) begin n_err++; $display("FAIL reset_rem got %h want 0", data_remainder); end
`endif
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_vectors;
    logic [W-1:0] ta [5] = '{32'd100, 32'hFFFFFF9C, 32'd100, 32'h80000000, 32'h80000000};
    logic [W-1:0] tb [5] = '{32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd2};
    logic [W-1:0] tq [5] = '{32'd14, 32'hFFFFFFF2, 32'hFFFFFFF2, 32'h80000000, 32'hC0000000};
    logic [W-1:0] tr [5] = '{32'd2, 32'hFFFFFFFE, 32'd2, 32'd0, 32'd0};
    int lat;
    for (int i = 0; i < 5; i++) begin
      start_op(ta[i], tb[i]);
      wait_rdy(40, lat);
      n_vec++; if (lat != 33) begin n_err++; $display("FAIL vec%0d_latency got %0d want 33", i, lat); end
      n_vec++; if (data_result !== tq[i]) begin n_err++; $display("FAIL vec%0d_result got %h want %h", i, data_result, tq[i]); end
      n_vec++; if (data_exception !== 1'b0) begin n_err++; $display("FAIL vec%0d_exc got %b want 0", i, data_exception); end
`ifdef DIV_REMAINDER_EN
      n_vec++; if (data_remainder !== tr[i]) begin n_err++; $display("FAIL vec%0d_rem got %h want %h", i, data_remainder, tr[i]); end
`endif
      @(posedge clock);
      #1;
      n_vec++; if (data_resultRDY !== 1'b0) begin n_err++; $display("FAIL vec%0d_rdy_pulse got %b want 0", i, data_resultRDY); end
    end
  endtask

  task automatic test_div_zero;
    int lat;
    start_op(32'd5, 32'd0);
    wait_rdy(40, lat);
    n_vec++; if (lat != 1) begin n_err++; $display("FAIL dz_latency got %0d want 1", lat); end
    n_vec++; if (data_exception !== 1'b1) begin n_err++; $display("FAIL dz_exc got %b want 1", data_exception); end
    n_vec++; if (data_result !== '0) begin n_err++; $display("FAIL dz_result got %h want 0", data_result); end
`ifdef DIV_REMAINDER_EN
    n_vec++; if (data_remainder !== '0) begin n_err++; $display("FAIL dz_rem got %h want 0", data_remainder); end
`endif
    @(posedge clock);
    #1;
    n_vec++; if (data_resultRDY !== 1'b0) begin n_err++; $display("FAIL dz_rdy_pulse got %b want 0", data_resultRDY); end
    n_vec++; if (data_exception !== 1'b1) begin n_err++; $display("FAIL dz_exc_hold got %b want 1", data_exception); end
    start_op(32'd9, 32'd3);
    n_vec++; if (data_exception !== 1'b0) begin n_err++; $display("FAIL dz_exc_clear got %b want 0", data_exception); end
    wait_rdy(40, lat);
    n_vec++; if (lat != 33) begin n_err++; $display("FAIL dz_next_latency got %0d want 33", lat); end
    n_vec++; if (data_result !== 32'd3) begin n_err++; $display("FAIL dz_next_result got %h want 3", data_result); end
  endtask

  task automatic test_restart;
    int lat;
    int pulses = 0;
    start_op(32'd1000, 32'd3);
    repeat (9) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) pulses++;
    end
    start_op(32'd50, 32'd5);
    wait_rdy(60, lat);
    n_vec++; if (pulses != 0) begin n_err++; $display("FAIL restart_early_rdy got %0d want 0", pulses); end
    n_vec++; if (lat != 33) begin n_err++; $display("FAIL restart_latency got %0d want 33", lat); end
    n_vec++; if (data_result !== 32'd10) begin n_err++; $display("FAIL restart_result got %h want a", data_result); end
  endtask

  task automatic test_back_to_back;
    int lat;
    int pulses = 0;
    logic [W-1:0] la, lb;
    la = '0;
    lb = 32'd1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      la = $urandom;
      lb = 32'($urandom_range(1, 1000));
      operandA = la;
      operandB = lb;
      ctrl_div = 1'b1;
      @(posedge clock);
      #1;
      if (data_resultRDY) pulses++;
    end
    ctrl_div = 1'b0;
    operandA = $urandom;
    operandB = '0;
    wait_rdy(60, lat);
    n_vec++; if (pulses != 0) begin n_err++; $display("FAIL held_rdy_while_high got %0d want 0", pulses); end
    n_vec++; if (lat != 33) begin n_err++; $display("FAIL held_latency got %0d want 33", lat); end
    n_vec++; if (data_result !== ref_quot(la, lb)) begin n_err++; $display("FAIL held_result got %h want %h", data_result, ref_quot(la, lb)); end
  endtask

  task automatic test_reset_mid;
    int lat;
    int pulses = 0;
    start_op(32'd77, 32'd7);
    repeat (18) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_vec++; if (data_result !== '0) begin n_err++; $display("FAIL rstmid_result got %h want 0", data_result); end
    n_vec++; if (data_exception !== 1'b0) begin n_err++; $display("FAIL rstmid_exc got %b want 0", data_exception); end
    n_vec++; if (data_resultRDY !== 1'b0) begin n_err++; $display("FAIL rstmid_rdy got %b want 0", data_resultRDY); end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) pulses++;
    end
    n_vec++; if (pulses != 0) begin n_err++; $display("FAIL rstmid_stray_rdy got %0d want 0", pulses); end
    start_op(32'd77, 32'd7);
    wait_rdy(40, lat);
    n_vec++; if (lat != 33) begin n_err++; $display("FAIL rstmid_next_latency got %0d want 33", lat); end
    n_vec++; if (data_result !== 32'd11) begin n_err++; $display("FAIL rstmid_next_result got %h want b", data_result); end
  endtask

  task automatic test_random;
    int lat, sel, want_lat;
    logic [W-1:0] a, b;
    for (int n = 0; n < 60; n++) begin
      a   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = '0;
      else if (sel < 4)  b = 32'($urandom_range(1, 20));
      else if (sel == 4) b = 32'hFFFFFFFF;
      else               b = 32'($urandom);
      if (sel == 2 || sel == 3) b = -b;
      if (sel > 5) b = b >> $urandom_range(0, 30);
      if (b == '0) sel = 0;
      want_lat = (b == '0) ? 1 : 33;
      start_op(a, b);
      wait_rdy(40, lat);
      n_vec++; if (lat != want_lat) begin n_err++; $display("FAIL rnd%0d_latency a=%h b=%h got %0d want %0d", n, a, b, lat, want_lat); end
      n_vec++; if (data_result !== ref_quot(a, b)) begin n_err++; $display("FAIL rnd%0d_result a=%h b=%h got %h want %h", n, a, b, data_result, ref_quot(a, b)); end
      n_vec++; if (data_exception !== (b == '0)) begin n_err++; $display("FAIL rnd%0d_exc a=%h b=%h got %b want %b", n, a, b, data_exception, (b == '0)); end
`ifdef DIV_REMAINDER_EN
      n_vec++; if (data_remainder !== ref_rem(a, b)) begin n_err++; $display("FAIL rnd%0d_rem a=%h b=%h got %h want %h", n, a, b, data_remainder, ref_rem(a, b)); end
`endif
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_div_zero;
    test_restart;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
